// File: rtl/dbb_axi_mem_responder.sv
// AXI-style slave memory model answering the NVDLA dbb master port.
// Independent write and read FSMs (one outstanding burst each) over a 1R1W 64-bit word array.
module dbb_axi_mem_responder #(
    parameter int unsigned ADDR_W    = 12,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic        core_clk,
    input  logic        rst,
    input  logic        nvdla_core2dbb_aw_awvalid,
    output logic        nvdla_core2dbb_aw_awready,
    input  logic [7:0]  nvdla_core2dbb_aw_awid,
    input  logic [3:0]  nvdla_core2dbb_aw_awlen,
    input  logic [2:0]  nvdla_core2dbb_aw_awsize,
    input  logic [63:0] nvdla_core2dbb_aw_awaddr,
    input  logic        nvdla_core2dbb_w_wvalid,
    output logic        nvdla_core2dbb_w_wready,
    input  logic [63:0] nvdla_core2dbb_w_wdata,
    input  logic [7:0]  nvdla_core2dbb_w_wstrb,
    input  logic        nvdla_core2dbb_w_wlast,
    output logic        nvdla_core2dbb_b_bvalid,
    input  logic        nvdla_core2dbb_b_bready,
    output logic [7:0]  nvdla_core2dbb_b_bid,
    input  logic        nvdla_core2dbb_ar_arvalid,
    output logic        nvdla_core2dbb_ar_arready,
    input  logic [7:0]  nvdla_core2dbb_ar_arid,
    input  logic [3:0]  nvdla_core2dbb_ar_arlen,
    input  logic [2:0]  nvdla_core2dbb_ar_arsize,
    input  logic [63:0] nvdla_core2dbb_ar_araddr,
    output logic        nvdla_core2dbb_r_rvalid,
    input  logic        nvdla_core2dbb_r_rready,
    output logic [7:0]  nvdla_core2dbb_r_rid,
    output logic        nvdla_core2dbb_r_rlast,
    output logic [63:0] nvdla_core2dbb_r_rdata,
    output logic        wlast_err
);
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

    logic [63:0] r_mem [DEPTH];

    wstate_t r_wstate, w_wstate_nxt;
    rstate_t r_rstate, w_rstate_nxt;

    logic [ADDR_W-1:0] r_widx, r_ridx;
    logic [4:0]        r_wcnt, r_rcnt;
    logic              r_awready, r_wready, r_bvalid, r_wlast_err;
    logic              r_arready, r_rvalid, r_rlast;
    logic [7:0]        r_bid, r_rid;
    logic [63:0]       r_rdata;

    logic [63:0]       w_aw_off, w_ar_off;
    logic [ADDR_W-1:0] w_aw_idx, w_ar_idx;
    logic              w_aw_hs, w_w_hs, w_w_end, w_w_err, w_ar_hs, w_r_hs;
    logic              w_unused;

    assign w_aw_off = nvdla_core2dbb_aw_awaddr - BASE_ADDR;
    assign w_ar_off = nvdla_core2dbb_ar_araddr - BASE_ADDR;
    assign w_aw_idx = w_aw_off[ADDR_W+2:3];
    assign w_ar_idx = w_ar_off[ADDR_W+2:3];
    assign w_unused = ^{nvdla_core2dbb_aw_awsize, nvdla_core2dbb_ar_arsize, w_aw_off, w_ar_off};

    // ---------------- write path ----------------
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_aw_hs      = 1'b0;
        w_w_hs       = 1'b0;
        w_w_end      = 1'b0;
        w_w_err      = 1'b0;
        case (r_wstate)
            W_IDLE: if (nvdla_core2dbb_aw_awvalid && r_awready) begin
                w_aw_hs      = 1'b1;
                w_wstate_nxt = W_DATA;
            end
            W_DATA: if (nvdla_core2dbb_w_wvalid && r_wready) begin
                w_w_hs  = 1'b1;
                // A burst ends on whichever comes first: wlast or the beat count running out.
                w_w_end = nvdla_core2dbb_w_wlast || (r_wcnt == 5'd1);
                w_w_err = nvdla_core2dbb_w_wlast != (r_wcnt == 5'd1);
                if (w_w_end) w_wstate_nxt = W_RESP;
            end
            W_RESP: if (nvdla_core2dbb_b_bready && r_bvalid) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (rst) begin
            r_wstate    <= W_IDLE;
            r_awready   <= 1'b0;
            r_wready    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_wlast_err <= 1'b0;
            r_bid       <= '0;
            r_widx      <= '0;
            r_wcnt      <= '0;
        end else begin
            r_wstate    <= w_wstate_nxt;
            r_awready   <= (w_wstate_nxt == W_IDLE);
            r_wready    <= (w_wstate_nxt == W_DATA);
            r_bvalid    <= (w_wstate_nxt == W_RESP);
            r_wlast_err <= w_w_hs && w_w_err;
            if (w_aw_hs) begin
                r_bid  <= nvdla_core2dbb_aw_awid;
                r_widx <= w_aw_idx;
                r_wcnt <= {1'b0, nvdla_core2dbb_aw_awlen} + 5'd1;
            end else if (w_w_hs) begin
                r_widx <= r_widx + IDX_ONE;
                r_wcnt <= r_wcnt - 5'd1;
            end
        end
    end

    always_ff @(posedge core_clk) begin
        if (w_w_hs && !rst) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (nvdla_core2dbb_w_wstrb[i]) r_mem[r_widx][i*8 +: 8] <= nvdla_core2dbb_w_wdata[i*8 +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_ar_hs      = 1'b0;
        w_r_hs       = 1'b0;
        case (r_rstate)
            R_IDLE: if (nvdla_core2dbb_ar_arvalid && r_arready) begin
                w_ar_hs      = 1'b1;
                w_rstate_nxt = R_DATA;
            end
            R_DATA: if (nvdla_core2dbb_r_rready && r_rvalid) begin
                w_r_hs = 1'b1;
                if (r_rlast) w_rstate_nxt = R_IDLE;
            end
        endcase
    end

    // r_ridx points at the word for the beat after the one currently presented.
    always_ff @(posedge core_clk) begin
        if (rst) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rid     <= '0;
            r_rdata   <= '0;
            r_ridx    <= '0;
            r_rcnt    <= '0;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_arready <= (w_rstate_nxt == R_IDLE);
            r_rvalid  <= (w_rstate_nxt == R_DATA);
            if (w_ar_hs) begin
                r_rid   <= nvdla_core2dbb_ar_arid;
                r_rdata <= r_mem[w_ar_idx];
                r_ridx  <= w_ar_idx + IDX_ONE;
                r_rcnt  <= {1'b0, nvdla_core2dbb_ar_arlen} + 5'd1;
                r_rlast <= (nvdla_core2dbb_ar_arlen == 4'd0);
            end else if (w_r_hs && !r_rlast) begin
                r_rdata <= r_mem[r_ridx];
                r_ridx  <= r_ridx + IDX_ONE;
                r_rcnt  <= r_rcnt - 5'd1;
                r_rlast <= (r_rcnt == 5'd2);
            end else if (w_r_hs) begin
                r_rlast <= 1'b0;
            end
        end
    end

    assign nvdla_core2dbb_aw_awready = r_awready;
    assign nvdla_core2dbb_w_wready   = r_wready;
    assign nvdla_core2dbb_b_bvalid   = r_bvalid;
    assign nvdla_core2dbb_b_bid      = r_bid;
    assign nvdla_core2dbb_ar_arready = r_arready;
    assign nvdla_core2dbb_r_rvalid   = r_rvalid;
    assign nvdla_core2dbb_r_rid      = r_rid;
    assign nvdla_core2dbb_r_rlast    = r_rlast;
    assign nvdla_core2dbb_r_rdata    = r_rdata;
    assign wlast_err                 = r_wlast_err;
endmodule

// File: doc/dbb_axi_mem_responder.md
Name: dbb_axi_mem_responder

Overview:
- AXI-style slave memory model that answers the NVDLA core's dbb master port (aw/w/b/ar/r channels, 64-bit data, 8-bit IDs, 4-bit lengths).
- Backed by an internal 1R1W word array.
- Used as the memory endpoint behind the small NVDLA top in simulation and FPGA bring-up.
- Write and read paths run independently, with one outstanding transaction per direction.

Parameters:
- ADDR_W, 12: log2 of memory depth in 64-bit words.
- BASE_ADDR, 64'h0: byte address mapped to word 0; subtracted before indexing.

Ports:
- core_clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- nvdla_core2dbb_aw_awvalid  in  1  write address valid
- nvdla_core2dbb_aw_awready  out  1  write address ready
- nvdla_core2dbb_aw_awid  in  8  write ID
- nvdla_core2dbb_aw_awlen  in  4  beats-1
- nvdla_core2dbb_aw_awsize  in  3  ignored; always 3'b011
- nvdla_core2dbb_aw_awaddr  in  64  byte address
- nvdla_core2dbb_w_wvalid  in  1  write data valid
- nvdla_core2dbb_w_wready  out  1  write data ready
- nvdla_core2dbb_w_wdata  in  64  write data
- nvdla_core2dbb_w_wstrb  in  8  byte enables
- nvdla_core2dbb_w_wlast  in  1  last write beat
- nvdla_core2dbb_b_bvalid  out  1  write response valid
- nvdla_core2dbb_b_bready  in  1  write response ready
- nvdla_core2dbb_b_bid  out  8  response ID (latched awid)
- nvdla_core2dbb_ar_arvalid  in  1  read address valid
- nvdla_core2dbb_ar_arready  out  1  read address ready
- nvdla_core2dbb_ar_arid  in  8  read ID
- nvdla_core2dbb_ar_arlen  in  4  beats-1
- nvdla_core2dbb_ar_arsize  in  3  ignored
- nvdla_core2dbb_ar_araddr  in  64  byte address
- nvdla_core2dbb_r_rvalid  out  1  read data valid
- nvdla_core2dbb_r_rready  in  1  read data ready
- nvdla_core2dbb_r_rid  out  8  read ID (latched arid)
- nvdla_core2dbb_r_rlast  out  1  last read beat
- nvdla_core2dbb_r_rdata  out  64  read data
- wlast_err  out  1  one-cycle pulse on wlast/awlen mismatch

Behaviour:
- Clock and reset: one clock, core_clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at a core_clk edge): both FSMs go to IDLE. All ready/valid outputs, rlast and wlast_err become 0. bid, rid and rdata become 0. Memory contents are not reset.
- Ready outputs are registered. awready and arready go to 1 on the first edge with rst=0.
- Address mapping: word index = ((addr - BASE_ADDR) >> 3) mod 2^ADDR_W. Addresses are assumed 8-byte aligned; low 3 bits are ignored.
- Bursts are INCR only. The index increments by 1 per beat and wraps from 2^ADDR_W-1 to 0.
- Write FSM, W_IDLE (awready=1):
  - On awvalid & awready, latch awid, index, and beat count awlen+1.
  - Next cycle: W_DATA, awready=0, wready=1.
- Write FSM, W_DATA:
  - Each wvalid & wready beat writes byte lanes where wstrb[i]=1; the index increments and the count decrements.
  - Burst ends on the beat where wlast=1 OR the count reaches 1, whichever comes first.
  - wlast_err pulses the cycle after the end beat if wlast disagrees with count==1.
  - Next cycle: W_RESP, wready=0, bvalid=1.
- Write FSM, W_RESP: bvalid held with bid stable until bready. The cycle after the handshake: W_IDLE, awready=1.
- Write latency: minimum 1 cycle from AW handshake to wready; 1 cycle from the last W handshake to bvalid.
- Read FSM, R_IDLE (arready=1):
  - On arvalid & arready, latch arid and count arlen+1, and load rdata from mem[index].
  - Next cycle: R_DATA, rvalid=1, rlast=(arlen==0).
- Read FSM, R_DATA:
  - rdata, rid and rlast are held stable while rvalid & !rready.
  - On a handshake with rlast=0: load the next word, increment the index, decrement the count; rvalid stays 1, no bubble.
  - On a handshake with rlast=1: next cycle rvalid=0, R_IDLE, arready=1.
- Read latency: first beat valid 1 cycle after the AR handshake; sustained throughput 1 beat per cycle.
- Simultaneous AW and AR handshakes are both accepted in the same cycle.
- Read/write collision: a read load in the same cycle as a write to the same word returns the pre-write data. Writes complete on the clock edge.
- Reset mid-operation: the transaction is abandoned. Words already written stay written. No response is issued.

Test Plan:
- Single beat: AW addr 0x40 len 0 id 0x12 + W 0xDEADBEEF_01234567 strb 0xFF wlast; then AR addr 0x40 len 0 id 0x34 -> bvalid with bid=0x12; rdata=0xDEADBEEF_01234567, rid=0x34, rlast=1 one cycle after AR.
- 16-beat burst: AW len 15 at 0x100, data=beat index, strb 0x0F on odd beats; then AR len 15 at 0x100 -> 16 consecutive beats. Odd beats have the upper 4 bytes holding prior contents. rlast only on beat 15.
- Backpressure: bready low 5 cycles -> bvalid and bid held. rready toggling every cycle -> rdata/rlast stable while stalled; beat order intact.
- Wrap and mismatch: ADDR_W=4, AW at word 15 len 1 -> words 15 and 0 written. Separately, wlast on beat 2 of len 3 -> burst ends, wlast_err pulses once, b response issued.
- Concurrency and reset: AW and AR in the same cycle to the same word -> both accepted and the read returns old data. Then rst asserted mid-read -> next cycle all valids 0; after release arready=1 and a new read succeeds.
